sipo_rx_ctrl: RTL and testbench

Frame-level controller that sequences a D_SIZE-bit serial-in/parallel-out shift path.
- Detects a start bit and counts exactly D_SIZE data bits into an internal shift register.
- Checks the stop bit, then presents the word on a valid/ready output port.
- Sits between a serial line, already sampled by an upstream strobe, and a parallel consumer.

---
 rtl/sipo_rx_ctrl_if.sv | 24 ++
 rtl/sipo_rx_ctrl.sv | 127 ++++++++++++
 tb/tb_sipo_rx_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_rx_ctrl_if.sv
// Serial-side and parallel-side signals of the SIPO frame receiver.
// master = line driver / consumer, slave = the receiver controller.
interface sipo_rx_ctrl_if #(
    parameter int D_SIZE = 4
);
    logic              bit_en;
    logic              serial_in;
    logic              data_ready;
    logic [D_SIZE-1:0] data_out;
    logic              data_valid;
    logic              busy;
    logic              frame_err;
    logic              overrun;

    modport master (
        output bit_en, serial_in, data_ready,
        input  data_out, data_valid, busy, frame_err, overrun
    );

    modport slave (
        input  bit_en, serial_in, data_ready,
        output data_out, data_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/sipo_rx_ctrl.sv
// Start/data/stop frame controller feeding a D_SIZE-bit MSB-first shift register.
// Optional even-parity bit after the data bits: define SIPO_RX_PARITY_EN.
module sipo_rx_ctrl #(
    parameter int D_SIZE = 4
) (
    input  logic            clk,
    input  logic            rst,
    sipo_rx_ctrl_if.slave   bus
);
    localparam int CW = $clog2(D_SIZE) + 1;

`ifdef SIPO_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, STOP = 2'd2, PARITY = 2'd3} state_e;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, STOP = 2'd2} state_e;
`endif

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [D_SIZE-1:0] shift_q, shift_d;
    logic [D_SIZE-1:0] dout_q, dout_d;
    logic              dv_q, dv_d;
    logic              fe_q, fe_d;
    logic              ov_q, ov_d;
    logic              good;
`ifdef SIPO_RX_PARITY_EN
    logic              par_err_q, par_err_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
`ifdef SIPO_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        dv_d    = dv_q;
        fe_d    = 1'b0;
        ov_d    = 1'b0;
        good    = 1'b0;
`ifdef SIPO_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        // Consumer handshake runs independently of bit_en; a load below overrides it.
        if (dv_q && bus.data_ready)
            dv_d = 1'b0;

        if (bus.bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!bus.serial_in) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
`ifdef SIPO_RX_PARITY_EN
                        par_err_d = 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    shift_d = {shift_q[D_SIZE-2:0], bus.serial_in};
                    cnt_d   = cnt_q + CW'(1);
`ifdef SIPO_RX_PARITY_EN
                    par_err_d = par_err_q ^ bus.serial_in;
                    if (cnt_q == CW'(D_SIZE - 1))
                        state_d = PARITY;
`else
                    if (cnt_q == CW'(D_SIZE - 1))
                        state_d = STOP;
`endif
                end
`ifdef SIPO_RX_PARITY_EN
                PARITY: begin
                    par_err_d = par_err_q ^ bus.serial_in;
                    state_d   = STOP;
                end
`endif
                STOP: begin
                    state_d = IDLE;
`ifdef SIPO_RX_PARITY_EN
                    good = bus.serial_in && !par_err_q;
`else
                    good = bus.serial_in;
`endif
                    if (!good) begin
                        fe_d = 1'b1;
                    end else if (!dv_q || bus.data_ready) begin
                        dout_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        ov_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.data_valid = dv_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_err  = fe_q;
    assign bus.overrun    = ov_q;
endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Scenario-task bench for sipo_rx_ctrl (D_SIZE=4); expected words queued per frame.
module tb_sipo_rx_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic par_flip;
    logic [3:0] exp_q[$];
    logic [3:0] exp_w;

    sipo_rx_ctrl_if #(.D_SIZE(4)) bus ();

    sipo_rx_ctrl #(.D_SIZE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobed bit, then `gap` unstrobed cycles with garbage on the line.
    task automatic send_bit(input logic b, input int gap);
        bus.serial_in = b;
        bus.bit_en    = 1'b1;
        tick();
        bus.bit_en = 1'b0;
        for (int i = 0; i < gap; i++) begin
            bus.serial_in = 1'($urandom);
            tick();
        end
    endtask

    // Returns just after the stop-bit edge.
    task automatic send_frame(input logic [3:0] w, input logic stop_b, input int gap, input logic rdy_stop);
        logic [3:0] wv;
        wv = w;
        send_bit(1'b0, gap);
        for (int i = 3; i >= 0; i--)
            send_bit(wv[i], gap);
`ifdef SIPO_RX_PARITY_EN
        send_bit((^wv) ^ par_flip, gap);
`else
        if (par_flip)
            $display("note: parity bit not sent in this build");
`endif
        bus.serial_in = stop_b;
        bus.bit_en    = 1'b1;
        if (rdy_stop)
            bus.data_ready = 1'b1;
        tick();
        bus.bit_en    = 1'b0;
        bus.serial_in = 1'b1;
        if (rdy_stop)
            bus.data_ready = 1'b0;
    endtask

    task automatic consume();
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
        checks++;
        if (bus.data_valid !== 1'b0) begin
            errors++;
            $display("FAIL consume_dv got %b exp 0", bus.data_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.bit_en = 1'b1;
        bus.data_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.serial_in = i[0];
            tick();
        end
        checks++;
        if (bus.data_out !== 4'b0000) begin errors++; $display("FAIL reset_dout got %b exp 0000", bus.data_out); end
        checks++;
        if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b exp 0", bus.data_valid); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++;
        if ({bus.frame_err, bus.overrun} !== 2'b00) begin
            errors++; $display("FAIL reset_pulses got %b%b exp 00", bus.frame_err, bus.overrun);
        end
        bus.bit_en = 1'b0;
        bus.serial_in = 1'b1;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        bus.data_ready = 1'b0;
        send_frame(4'b1011, 1'b1, 0, 1'b0);
        exp_q.push_back(4'b1011);
        checks++;
        if (bus.data_valid !== 1'b1) begin errors++; $display("FAIL nom_dv got %b exp 1", bus.data_valid); end
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.data_out !== exp_w) begin errors++; $display("FAIL nom_dout got %b exp %b", bus.data_out, exp_w); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL nom_busy got %b exp 0", bus.busy); end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({bus.data_valid, bus.data_out} !== {1'b1, exp_w}) begin
            errors++; $display("FAIL nom_hold got %b/%b exp 1/%b", bus.data_valid, bus.data_out, exp_w);
        end
        consume();
    endtask

    task automatic test_strobed();
        send_frame(4'b0110, 1'b1, 2, 1'b0);
        exp_q.push_back(4'b0110);
        exp_w = exp_q.pop_front();
        checks++;
        if ({bus.data_valid, bus.data_out} !== {1'b1, exp_w}) begin
            errors++; $display("FAIL strobe_word got %b/%b exp 1/%b", bus.data_valid, bus.data_out, exp_w);
        end
        consume();
    endtask

    task automatic test_bad_stop();
        send_frame(4'b1111, 1'b0, 0, 1'b0);
        checks++;
        if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL badstop_fe got %b exp 1", bus.frame_err); end
        checks++;
        if ({bus.data_valid, bus.data_out} !== {1'b0, 4'b0110}) begin
            errors++; $display("FAIL badstop_out got %b/%b exp 0/0110", bus.data_valid, bus.data_out);
        end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL badstop_busy got %b exp 0", bus.busy); end
        tick();
        checks++;
        if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL badstop_pulse got %b exp 0", bus.frame_err); end
    endtask

    task automatic test_overrun();
        send_frame(4'b1011, 1'b1, 0, 1'b0);
        exp_q.push_back(4'b1011);
        exp_w = exp_q.pop_front();
        checks++;
        if ({bus.data_valid, bus.data_out} !== {1'b1, exp_w}) begin
            errors++; $display("FAIL ovr_first got %b/%b exp 1/%b", bus.data_valid, bus.data_out, exp_w);
        end
        send_frame(4'b0101, 1'b1, 1, 1'b0);
        checks++;
        if ({bus.overrun, bus.frame_err} !== 2'b10) begin
            errors++; $display("FAIL ovr_pulse got ov=%b fe=%b exp ov=1 fe=0", bus.overrun, bus.frame_err);
        end
        checks++;
        if ({bus.data_valid, bus.data_out} !== {1'b1, 4'b1011}) begin
            errors++; $display("FAIL ovr_keep got %b/%b exp 1/1011", bus.data_valid, bus.data_out);
        end
        tick();
        checks++;
        if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_once got %b exp 0", bus.overrun); end
        send_frame(4'b0101, 1'b1, 0, 1'b1);
        exp_q.push_back(4'b0101);
        exp_w = exp_q.pop_front();
        checks++;
        if ({bus.data_valid, bus.data_out, bus.overrun} !== {1'b1, exp_w, 1'b0}) begin
            errors++; $display("FAIL ovr_replace got %b/%b ov=%b exp 1/%b ov=0",
                               bus.data_valid, bus.data_out, bus.overrun, exp_w);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        bus.data_ready = 1'b1;
        send_frame(4'b1001, 1'b1, 0, 1'b0);
        exp_q.push_back(4'b1001);
        exp_w = exp_q.pop_front();
        checks++;
        if ({bus.data_valid, bus.data_out} !== {1'b1, exp_w}) begin
            errors++; $display("FAIL b2b_first got %b/%b exp 1/%b", bus.data_valid, bus.data_out, exp_w);
        end
        send_frame(4'b0011, 1'b1, 0, 1'b0);
        bus.data_ready = 1'b0;
        exp_q.push_back(4'b0011);
        exp_w = exp_q.pop_front();
        checks++;
        if ({bus.data_valid, bus.data_out} !== {1'b1, exp_w}) begin
            errors++; $display("FAIL b2b_second got %b/%b exp 1/%b", bus.data_valid, bus.data_out, exp_w);
        end
    endtask

    task automatic test_mid_reset();
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        rst = 1'b0;
        tick();
        checks++;
        if ({bus.busy, bus.data_valid, bus.data_out} !== {1'b0, 1'b0, 4'b0000}) begin
            errors++; $display("FAIL midrst_state got busy=%b dv=%b dout=%b exp 0/0/0000",
                               bus.busy, bus.data_valid, bus.data_out);
        end
        rst = 1'b1;
        tick();
        send_frame(4'b1100, 1'b1, 0, 1'b0);
        exp_q.push_back(4'b1100);
        exp_w = exp_q.pop_front();
        checks++;
        if ({bus.data_valid, bus.data_out} !== {1'b1, exp_w}) begin
            errors++; $display("FAIL midrst_word got %b/%b exp 1/%b", bus.data_valid, bus.data_out, exp_w);
        end
        consume();
    endtask

`ifdef SIPO_RX_PARITY_EN
    task automatic test_parity();
        par_flip = 1'b1;
        send_frame(4'b1100, 1'b1, 0, 1'b0);
        par_flip = 1'b0;
        checks++;
        if ({bus.frame_err, bus.data_valid} !== 2'b10) begin
            errors++; $display("FAIL par_bad got fe=%b dv=%b exp fe=1 dv=0", bus.frame_err, bus.data_valid);
        end
        send_frame(4'b1100, 1'b1, 0, 1'b0);
        exp_q.push_back(4'b1100);
        exp_w = exp_q.pop_front();
        checks++;
        if ({bus.frame_err, bus.data_valid, bus.data_out} !== {1'b0, 1'b1, exp_w}) begin
            errors++; $display("FAIL par_good got fe=%b dv=%b dout=%b exp 0/1/%b",
                               bus.frame_err, bus.data_valid, bus.data_out, exp_w);
        end
        consume();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        par_flip = 1'b0;
        rst = 1'b0;
        bus.bit_en = 1'b0;
        bus.serial_in = 1'b1;
        bus.data_ready = 1'b0;
        test_reset();
        test_nominal();
        test_strobed();
        test_bad_stop();
        test_overrun();
        test_back_to_back();
        test_mid_reset();
`ifdef SIPO_RX_PARITY_EN
        test_parity();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
